uart_tx_fifo: RTL

//  Parametrised UART transmitter with a small input FIFO and a valid/ready write port.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_sync_fifo.sv | 45 ++++
 rtl/uart_tx_fifo.sv | 134 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter slice.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // Odd parity makes the total count of ones odd, so it is the inverse of the XOR reduction.
   function automatic logic parity_bit(input logic xor_red, input int mode);
      return (mode == PAR_ODD) ? ~xor_red : xor_red;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO; the head word is visible combinationally at the read pointer.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      level_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q, rptr_q;
   logic             push_ok, pop_ok;

   assign level_o = wptr_q - rptr_q;
   assign full_o  = (level_o == (AW+1)'(DEPTH));
   assign empty_o = (wptr_q == rptr_q);
   assign rdata_o = mem_q[rptr_q[AW-1:0]];

   // A push into a full FIFO is dropped even when a pop frees a slot on the same edge.
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push_ok) wptr_q <= wptr_q + 1'b1;
         if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO, valid/ready write port and configurable frame format.
//
// state  | meaning
// IDLE   | line at mark, waiting for a queued word
// START  | start bit (0)
// DATA   | payload bits, LSB first
// PARITY | parity bit, only when parity is enabled
// STOP   | stop bit(s) (1); chains into START when more words are queued
module uart_tx_fifo #(
   parameter int CLK_DIV    = 1302,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_BITS-1:0]          tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   import uart_pkg::*;

   localparam int CW = $clog2(CLK_DIV);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] RELOAD    = CW'(CLK_DIV - 1);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
   localparam bit            HAS_PAR   = (PARITY != PAR_NONE);

   tx_state_t            state_q;
   logic [CW-1:0]        baud_q;
   logic [BW-1:0]        bit_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_q;
   logic                 tx_q;

   logic [DATA_BITS-1:0] head;
   logic                 full, empty, pop, baud_tick, par_d;

   uart_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (tx_valid),
      .wdata_i (tx_data),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty),
      .level_o (fifo_level)
   );

   assign baud_tick = (baud_q == '0);
   assign par_d     = parity_bit(^head, PARITY);
   assign pop       = ~empty & ((state_q == IDLE) |
                                ((state_q == STOP) & baud_tick & (bit_q == LAST_STOP)));

   assign tx_ready = ~full;
   assign tx       = tx_q;
   assign busy     = (state_q != IDLE) | ~empty;

   // tx_q is the line value for the state held during the previous cycle, so tx trails the FSM by one clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         case (state_q)
            START:            tx_q <= 1'b0;
            DATA:             tx_q <= shift_q[0];
            uart_pkg::PARITY: tx_q <= par_q;
            default:          tx_q <= 1'b1;
         endcase

         if (state_q != IDLE) baud_q <= baud_tick ? RELOAD : baud_q - 1'b1;

         case (state_q)
            IDLE: begin
               if (pop) begin
                  shift_q <= head;
                  par_q   <= par_d;
                  baud_q  <= RELOAD;
                  state_q <= START;
               end
            end
            START: begin
               if (baud_tick) state_q <= DATA;
            end
            DATA: begin
               if (baud_tick) begin
                  shift_q <= shift_q >> 1;
                  if (bit_q == LAST_DATA) begin
                     bit_q   <= '0;
                     state_q <= HAS_PAR ? uart_pkg::PARITY : STOP;
                  end else begin
                     bit_q <= bit_q + 1'b1;
                  end
               end
            end
            uart_pkg::PARITY: begin
               if (baud_tick) state_q <= STOP;
            end
            STOP: begin
               if (baud_tick) begin
                  if (bit_q == LAST_STOP) begin
                     bit_q <= '0;
                     if (pop) begin
                        shift_q <= head;
                        par_q   <= par_d;
                        state_q <= START;
                     end else begin
                        state_q <= IDLE;
                     end
                  end else begin
                     bit_q <= bit_q + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
